// File: rtl/ledstrip_pkg.sv
// Shared types and constants for the LED-strip text sequencer.
// The state enum and glyph column extraction live here so every file slices glyphs the same way.
package ledstrip_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam int FONT_COLS = 5;
  localparam int FONT_ROWS = 7;
  localparam int GLYPH_W   = 35;
  localparam int ASCII_MIN = 32;

  // Column 0 sits in the top bits of the glyph word; bit 0 of each column is the top pixel row.
  function automatic logic [FONT_ROWS-1:0] glyph_col(input logic [GLYPH_W-1:0] glyph,
                                                    input logic [2:0] col);
    return glyph[GLYPH_W - 1 - FONT_ROWS * int'(col) -: FONT_ROWS];
  endfunction

endpackage

// File: rtl/ledstrip_text_buf.sv
// Text buffer: NUM_CHARS x 7-bit register file, one write port and one combinational read port.
// Reset fills every slot with ASCII space.
module ledstrip_text_buf
  import ledstrip_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int IDX_W     = $clog2(NUM_CHARS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [FONT_ROWS-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_addr,
  output logic [FONT_ROWS-1:0] rd_data
);

  logic [FONT_ROWS-1:0] mem [NUM_CHARS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHARS; i++) mem[i] <= 7'h20;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ledstrip_text_sequencer.sv
// Glyph sequencer: fetches each buffered character's glyph and streams its columns plus gap columns.
// Optional macro LEDSTRIP_LOOP_EN: with start held high the message repeats as a continuous marquee.
module ledstrip_text_sequencer
  import ledstrip_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int GAP_COLS  = 1,
  parameter int IDX_W     = $clog2(NUM_CHARS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [6:0]           wr_data,
  input  logic [IDX_W-1:0]     msg_last,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [6:0]           rom_addr,
  input  logic [GLYPH_W-1:0]   rom_data,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic [6:0]           col_data,
  output logic                 col_last
);

  localparam logic [2:0] LAST_COL = 3'(FONT_COLS - 1);
  localparam logic [1:0] GAP_LAST = (GAP_COLS > 0) ? 2'(GAP_COLS - 1) : 2'd0;

  state_t               state;
  logic [IDX_W-1:0]     char_idx;
  logic [IDX_W-1:0]     last_idx;
  logic [GLYPH_W-1:0]   glyph;
  logic [2:0]           col_idx;
  logic [1:0]           gap_cnt;
  logic [6:0]           rom_addr_q;
  logic [6:0]           rd_data;
  logic                 final_char;
  logic                 char_end;

  ledstrip_text_buf #(
    .NUM_CHARS (NUM_CHARS),
    .IDX_W     (IDX_W)
  ) u_text_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (char_idx),
    .rd_data (rd_data)
  );

  // The ROM address follows the buffer only during FETCH so a write landing just before the fetch is seen.
  assign rom_addr   = (state == S_FETCH) ? rd_data : rom_addr_q;
  assign final_char = (char_idx == last_idx);

  always_comb begin
    char_end = 1'b0;
    if (col_valid && col_ready) begin
      if (state == S_EMIT && col_idx == LAST_COL && GAP_COLS == 0) char_end = 1'b1;
      if (state == S_GAP && gap_cnt == GAP_LAST)                   char_end = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      char_idx   <= '0;
      last_idx   <= '0;
      glyph      <= '0;
      col_idx    <= '0;
      gap_cnt    <= '0;
      rom_addr_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      col_valid  <= 1'b0;
      col_data   <= '0;
      col_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            last_idx <= msg_last;
            char_idx <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          glyph      <= rom_data;
          rom_addr_q <= rd_data;
          col_idx    <= '0;
          col_valid  <= 1'b1;
          col_data   <= glyph_col(rom_data, 3'd0);
          col_last   <= 1'b0;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (col_valid && col_ready) begin
            if (col_idx != LAST_COL) begin
              col_idx  <= col_idx + 3'd1;
              col_data <= glyph_col(glyph, col_idx + 3'd1);
              col_last <= (GAP_COLS == 0) && final_char && (col_idx + 3'd1 == LAST_COL);
            end else if (GAP_COLS > 0) begin
              gap_cnt  <= '0;
              col_data <= '0;
              col_last <= final_char && (GAP_LAST == 2'd0);
              state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (col_valid && col_ready && gap_cnt != GAP_LAST) begin
            gap_cnt  <= gap_cnt + 2'd1;
            col_last <= final_char && (gap_cnt + 2'd1 == GAP_LAST);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Last column of a character: move on, wrap, or finish the pass.
      if (char_end) begin
        col_valid <= 1'b0;
        col_last  <= 1'b0;
        col_data  <= '0;
        if (!final_char) begin
          char_idx <= char_idx + IDX_W'(1);
          state    <= S_FETCH;
        end
`ifdef LEDSTRIP_LOOP_EN
        else if (start) begin
          char_idx <= '0;
          state    <= S_FETCH;
        end
`endif
        else begin
          done  <= 1'b1;
          state <= S_DONE;
        end
      end
    end
  end

endmodule

// File: doc/ledstrip_text_sequencer.md
Name: ledstrip_text_sequencer

Overview:
- Sequences the 5x7 character glyph ROM for the LED-strip peripheral.
- Holds a small text buffer written by the CPU and, on start, looks up each character's 35-bit glyph.
- Streams the glyph column by column (7-bit columns, plus blank gap columns) to the downstream strip serializer over a valid/ready handshake.
- The glyph ROM is instantiated by the parent; this block drives its address and samples its data.

Parameters:
- NUM_CHARS, 8, text buffer depth (power of 2, 2..16).
- GAP_COLS, 1, blank columns emitted after each character (0..3).
- IDX_W, $clog2(NUM_CHARS), buffer index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  text buffer write strobe.
- wr_addr  in  IDX_W  buffer slot written.
- wr_data  in  7  ASCII code written.
- msg_last  in  IDX_W  index of last character in message (length-1); sampled on start.
- start  in  1  begin a pass (level-sampled in IDLE).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after final column handshake.
- rom_addr  out  7  glyph ROM address (ASCII code).
- rom_data  in  35  glyph ROM data, combinational from rom_addr.
- col_valid  out  1  column available.
- col_ready  in  1  downstream accepts column.
- col_data  out  7  column pixels, bit 0 = top row.
- col_last  out  1  marks final column of the message.

Behaviour:
- Reset values: all outputs 0; state IDLE; buffer contents 0x20 (space); char index 0.
- Glyph layout: column c (0..4) = rom_data[34-7c -: 7]. The ROM's out-of-range (<32) all-ones glyph is passed through unmodified.
- States: IDLE, FETCH, EMIT, GAP, DONE.
- IDLE: on start=1, latch msg_last, clear char index, go to FETCH.
- FETCH (1 cycle):
  - rom_addr = buf[char_idx].
  - Latch rom_data into a 35-bit glyph register at the cycle end.
  - Clear col index; go to EMIT.
  - rom_addr holds its last value outside FETCH.
- EMIT:
  - col_valid=1; col_data = glyph column col_idx.
  - Advance only on col_valid && col_ready. col_data and col_last are stable while stalled.
  - After col 4: if GAP_COLS>0 go to GAP, else go to the next character.
- GAP:
  - col_valid=1, col_data=0 for GAP_COLS handshakes.
  - Gap columns are also emitted after the last character.
- Next character: if char_idx==msg_last go to DONE, else char_idx+1 and FETCH.
- col_last=1 on the final column of the final character: the last gap column if GAP_COLS>0, else glyph column 4.
- DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge N; FETCH in cycle N+1; first col_valid in cycle N+2. One bubble cycle between characters (FETCH).
- Per-pass column count = (msg_last+1)*(5+GAP_COLS).
- Buffer writes:
  - Accepted in any state.
  - The glyph already latched is unaffected.
  - A write to a slot not yet fetched is visible when that slot is fetched.
  - Write and FETCH of the same slot in the same cycle: FETCH reads the old value.
- start while busy is ignored. msg_last changes while busy are ignored until the next start.
- rst_n assertion mid-pass: immediate return to reset values; col_valid drops asynchronously; buffer reinitialised to spaces.

Optional Feature:
- Macro: LEDSTRIP_LOOP_EN.
- Defined: after the final column handshake, if start is still 1, wrap char_idx to 0 and go to FETCH without DONE/done (continuous marquee). If start is 0, go to DONE as normal. col_last still pulses once per pass.
- Undefined: single pass; start must return to IDLE before it is honoured again.

Decomposition:
- Package ledstrip_pkg holds:
  - state enum.
  - FONT_COLS=5, FONT_ROWS=7, GLYPH_W=35, ASCII_MIN=32.
  - Column extraction function.
- One natural sub-module: ledstrip_text_buf, the NUM_CHARS x 7 register file with async reset to 0x20, one write port and one combinational read port.
- The FSM stays in the top module.

Test Plan:
- Reset: rst_n=0 -> busy=0, col_valid=0, done=0, rom_addr=0. Buffer reads back 0x20 via a pass emitting blank columns for ROM space glyph.
- Single char: buf[0]=0x41 ('A'), msg_last=0, GAP_COLS=1, col_ready=1, start pulse -> rom_addr=0x41 in FETCH; 6 columns matching model glyph cols 0..4 then 0x00; col_last on 6th; done pulse next cycle.
- Backpressure: "HI" with col_ready random 30% -> identical 12-column sequence, data stable while stalled, no drops or duplicates.
- Mid-pass write: during EMIT of char 0 of "ABCD", write slot 2=0x5A -> third glyph emitted is 'Z'. Write slot 0 -> no effect on the current glyph.
- Non-printable: buf[0]=0x05 -> five columns of 0x7F.
- Reset mid-pass and loop: assert rst_n low during EMIT -> col_valid=0 same cycle, state IDLE. With LEDSTRIP_LOOP_EN, start held high -> columns repeat seamlessly, col_last once per pass. Drop start -> done after the current pass.
